down_counter_timer: RTL and testbench
=====================================

// Module: down_counter_timer
// PURPOSE
//   Loadable, prescaled 32-bit down-counter timer: the counting-down complement of the free-running up-counter.
//   Software or a controlling FSM loads a value and starts it. The timer then counts to zero, emits a one-cycle done pulse and optionally auto-reloads.
//   Sits beside the up-counter in the timing subsystem. It generates timeouts and periodic events.
// PARAMETERS
//   WIDTH       32  width of load_value / count
//   PRESCALE_W  8   width of prescale input; decrement every (prescale+1) clk cycles
//   RCNT_W      16  width of reload_count (saturating)
// PORTS
//   clk           in   1           system clock, rising edge
//   reset         in   1           asynchronous, active-low reset (0 = reset)
//   load          in   1           load request, sampled on clk
//   load_value    in   WIDTH       value captured on accepted load
//   prescale      in   PRESCALE_W  ticks-per-decrement minus 1; sampled every cycle
//   start         in   1           start/resume request
//   pause         in   1           pause request
//   auto_reload   in   1           1 = reload from reload register at terminal count
//   count         out  WIDTH       current count value (registered)
//   running       out  1           1 iff state == RUN
//   done          out  1           one-cycle pulse on terminal count
//   reload_count  out  RCNT_W      number of auto-reloads since reset, saturates at all-ones
// BEHAVIOUR
//   Reset (reset==0, async): count=0, running=0, done=0, reload_count=0, reload_reg=0, presc_cnt=0, state=IDLE.
//   States: IDLE, LOADED, RUN, PAUSE, DONE. All outputs are registered, with no combinational input->output paths.
//   load accepted in IDLE/LOADED/DONE/PAUSE:
//     - count<=load_value and reload_reg<=load_value.
//     - From IDLE/LOADED/DONE the next state is LOADED. PAUSE stays PAUSE with the new count.
//     - load in RUN is ignored.
//   Priority in one cycle: pause > load > start. load+start together in IDLE: load taken, start ignored.
//   start in LOADED/PAUSE with count!=0: next state RUN. LOADED clears presc_cnt; PAUSE keeps it.
//   start with count==0 is ignored.
//   start in DONE with reload_reg!=0: count<=reload_reg, presc_cnt<=0, next state RUN.
//   RUN, each cycle:
//     - If presc_cnt==prescale: presc_cnt<=0 and a decrement tick occurs. Otherwise presc_cnt++.
//     - First decrement lands (prescale+1) cycles after the start edge.
//     - A prescale change mid-run takes effect on the next compare. If presc_cnt>prescale, the compare is still ==, so presc_cnt wraps naturally.
//   Tick with count>1: count<=count-1.
//   Tick with count==1 (terminal count):
//     - done<=1 for exactly one cycle, coincident with the cycle count shows its terminal value.
//     - auto_reload==1: count<=reload_reg, stay RUN, reload_count<=reload_count+1 (saturate).
//     - auto_reload==0: count<=0, next state DONE, running<=0.
//   pause in RUN: next state PAUSE. count and presc_cnt freeze, and no tick occurs that cycle.
//   pause outside RUN: no effect.
//   done is never high outside the cycle after a terminal tick. No wrap below zero ever occurs.
//   reset asserted mid-operation: immediate return to reset values. After release, state is IDLE.
// STRUCTURE
//   Shared package timer_pkg holds:
//     - typedef enum logic [2:0] timer_state_t {IDLE, LOADED, RUN, PAUSE, DONE}
//     - localparams for default WIDTH, PRESCALE_W and RCNT_W
//   Sub-module timer_prescaler (clk, reset, en, clr, prescale -> tick) implements presc_cnt and the compare.
//   The top level holds the FSM, count, reload_reg and reload_count.
// TESTING
//   1. prescale=0, load 5, start -> count 4,3,2,1 on consecutive cycles, then 0 with done=1 for 1 cycle.
//      State ends in DONE, running=0.
//   2. prescale=3, load 5, start -> count decrements every 4 cycles, and done fires 20 cycles after start.
//   3. auto_reload=1, prescale=0, load 3, start -> done every 3 cycles and count cycles 2,1,3,2,1,3...
//      reload_count increments 1,2,3.
//   4. prescale=3, load 10, start, pause 2 cycles after the first decrement -> count holds 9 for 10 cycles.
//      start resumes, and the next decrement occurs 2 cycles later (phase kept).
//   5. load 7 during RUN -> ignored, countdown unaffected.
//      load 7 + start in the same cycle from IDLE -> count=7, state LOADED, running=0.
//   6. reset driven low mid-run, asynchronously between edges -> count=0, running=0 and done=0 immediately.
//      After release, start is ignored until a load.

Source files
------------

// File: rtl/timer_pkg.sv
// timer_pkg: shared state encoding and default widths for the timer blocks
package timer_pkg;

    typedef enum logic [2:0] {IDLE, LOADED, RUN, PAUSE, DONE} timer_state_t;

    localparam int DEF_WIDTH      = 32;
    localparam int DEF_PRESCALE_W = 8;
    localparam int DEF_RCNT_W     = 16;

endpackage

// File: rtl/timer_prescaler.sv
// timer_prescaler: divides clk into decrement ticks every (prescale+1) enabled cycles
module timer_prescaler
    import timer_pkg::*;
#(
    parameter int PRESCALE_W = DEF_PRESCALE_W
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  en,
    input  logic                  clr,
    input  logic [PRESCALE_W-1:0] prescale,
    output logic                  tick
);

    logic [PRESCALE_W-1:0] presc_cnt;

    // Equality compare only, so a shrinking prescale lets presc_cnt wrap through zero
    assign tick = en && (presc_cnt == prescale);

    // Phase counter: cleared on fresh starts, frozen while disabled
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) presc_cnt <= '0;
        else if (clr) presc_cnt <= '0;
        else if (en) presc_cnt <= tick ? '0 : presc_cnt + 1'b1;
    end

endmodule

// File: rtl/down_counter_timer.sv
// down_counter_timer: loadable prescaled down-counter with done pulse and auto-reload
module down_counter_timer
    import timer_pkg::*;
#(
    parameter int WIDTH      = DEF_WIDTH,
    parameter int PRESCALE_W = DEF_PRESCALE_W,
    parameter int RCNT_W     = DEF_RCNT_W
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  load,
    input  logic [WIDTH-1:0]      load_value,
    input  logic [PRESCALE_W-1:0] prescale,
    input  logic                  start,
    input  logic                  pause,
    input  logic                  auto_reload,
    output logic [WIDTH-1:0]      count,
    output logic                  running,
    output logic                  done,
    output logic [RCNT_W-1:0]     reload_count
);

    timer_state_t      state, state_nxt;
    logic [WIDTH-1:0]  count_nxt, reload_reg, reload_nxt;
    logic [RCNT_W-1:0] rcnt_nxt;
    logic              done_nxt, en, clr, tick;

    // Ticks only count in RUN; pause wins so the paused cycle never ticks
    assign en = (state == RUN) && !pause;

    // Fresh starts from LOADED or DONE restart the prescale phase; PAUSE resumes it
    assign clr = start && !load &&
                 ((state == LOADED && count != '0) || (state == DONE && reload_reg != '0));

    assign running = (state == RUN);

    timer_prescaler #(.PRESCALE_W(PRESCALE_W)) u_presc (
        .clk      (clk),
        .reset    (reset),
        .en       (en),
        .clr      (clr),
        .prescale (prescale),
        .tick     (tick)
    );

    // Next-state, count and reload bookkeeping
    always_comb begin
        state_nxt  = state;
        count_nxt  = count;
        reload_nxt = reload_reg;
        rcnt_nxt   = reload_count;
        done_nxt   = 1'b0;
        if (state == RUN) begin
            if (pause) state_nxt = PAUSE;
            else if (tick && count == WIDTH'(1)) begin
                done_nxt = 1'b1;
                if (auto_reload) begin
                    count_nxt = reload_reg;
                    rcnt_nxt  = &reload_count ? reload_count : reload_count + 1'b1;
                end else begin
                    count_nxt = '0;
                    state_nxt = DONE;
                end
            end else if (tick && count > WIDTH'(1)) count_nxt = count - 1'b1;
        end else if (load) begin
            count_nxt  = load_value;
            reload_nxt = load_value;
            state_nxt  = (state == PAUSE) ? PAUSE : LOADED;
        end else if (start) begin
            if ((state == LOADED || state == PAUSE) && count != '0) state_nxt = RUN;
            else if (state == DONE && reload_reg != '0) begin
                count_nxt = reload_reg;
                state_nxt = RUN;
            end
        end
    end

    // State and output registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            count        <= '0;
            reload_reg   <= '0;
            reload_count <= '0;
            done         <= 1'b0;
        end else begin
            state        <= state_nxt;
            count        <= count_nxt;
            reload_reg   <= reload_nxt;
            reload_count <= rcnt_nxt;
            done         <= done_nxt;
        end
    end

endmodule

// File: tb/tb_down_counter_timer.sv
// tb_down_counter_timer: scoreboard bench for the prescaled down-counter timer
module tb_down_counter_timer;
    import timer_pkg::*;

    typedef struct {
        logic [31:0] count;
        logic        running;
        logic        done;
        logic [15:0] rc;
    } exp_t;

    logic        clk, reset, load, start, pause, auto_reload;
    logic [31:0] load_value, count;
    logic [7:0]  prescale;
    logic        running, done;
    logic [15:0] reload_count;

    exp_t q[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   n;

    timer_state_t m_state;
    logic [31:0]  m_count, m_rr;
    logic [7:0]   m_presc;
    logic [15:0]  m_rc;
    logic         m_done;

    down_counter_timer dut (
        .clk          (clk),
        .reset        (reset),
        .load         (load),
        .load_value   (load_value),
        .prescale     (prescale),
        .start        (start),
        .pause        (pause),
        .auto_reload  (auto_reload),
        .count        (count),
        .running      (running),
        .done         (done),
        .reload_count (reload_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_state = IDLE;
        m_count = '0;
        m_rr    = '0;
        m_presc = '0;
        m_rc    = '0;
        m_done  = 1'b0;
    endtask

    // Behavioural reference: advances one clock using the inputs currently driven
    task automatic model();
        logic tk;
        m_done = 1'b0;
        if (m_state == RUN) begin
            if (pause) m_state = PAUSE;
            else begin
                tk = (m_presc == prescale);
                m_presc = tk ? 8'd0 : m_presc + 8'd1;
                if (tk) begin
                    if (m_count == 32'd1) begin
                        m_done = 1'b1;
                        if (auto_reload) begin
                            m_count = m_rr;
                            if (m_rc != 16'hffff) m_rc = m_rc + 16'd1;
                        end else begin
                            m_count = '0;
                            m_state = DONE;
                        end
                    end else m_count = m_count - 32'd1;
                end
            end
        end else if (load) begin
            m_count = load_value;
            m_rr    = load_value;
            if (m_state != PAUSE) m_state = LOADED;
        end else if (start) begin
            if ((m_state == LOADED || m_state == PAUSE) && m_count != 0) begin
                if (m_state == LOADED) m_presc = '0;
                m_state = RUN;
            end else if (m_state == DONE && m_rr != 0) begin
                m_count = m_rr;
                m_presc = '0;
                m_state = RUN;
            end
        end
    endtask

    task automatic step();
        exp_t e;
        model();
        e.count   = m_count;
        e.running = (m_state == RUN);
        e.done    = m_done;
        e.rc      = m_rc;
        q.push_back(e);
        @(posedge clk);
        #1;
        e = q.pop_front();
        check("count", count, e.count);
        check("running", 32'(running), 32'(e.running));
        check("done", 32'(done), 32'(e.done));
        check("reload_count", 32'(reload_count), 32'(e.rc));
    endtask

    task automatic drive(input logic l, input logic [31:0] lv, input logic s, input logic p);
        load       = l;
        load_value = lv;
        start      = s;
        pause      = p;
        step();
        load  = 1'b0;
        start = 1'b0;
        pause = 1'b0;
    endtask

    initial begin
        logic [31:0] t3_seq [3];
        t3_seq = '{32'd2, 32'd1, 32'd3};
        reset = 1'b0; load = 1'b0; load_value = '0; prescale = '0;
        start = 1'b0; pause = 1'b0; auto_reload = 1'b0;
        model_reset();
        #2;
        check("rst_count", count, 32'd0);
        check("rst_running", 32'(running), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_rc", 32'(reload_count), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b1;

        prescale = 8'd0;
        drive(1'b1, 32'd5, 1'b0, 1'b0);
        drive(1'b0, 32'd0, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) begin
            step();
            check("t1_count", count, 32'(4 - i));
        end
        check("t1_done", 32'(done), 32'd1);
        check("t1_running", 32'(running), 32'd0);
        step();
        check("t1_done_pulse", 32'(done), 32'd0);

        prescale = 8'd3;
        drive(1'b1, 32'd5, 1'b0, 1'b0);
        drive(1'b0, 32'd0, 1'b1, 1'b0);
        n = 0;
        do begin
            step();
            n++;
        end while (!done && n < 100);
        check("t2_latency", 32'(n), 32'd20);

        prescale = 8'd0;
        auto_reload = 1'b1;
        drive(1'b1, 32'd3, 1'b0, 1'b0);
        drive(1'b0, 32'd0, 1'b1, 1'b0);
        for (int i = 0; i < 9; i++) begin
            step();
            check("t3_count", count, t3_seq[i % 3]);
            check("t3_done", 32'(done), 32'(i % 3 == 2));
        end
        check("t3_rc", 32'(reload_count), 32'd3);
        auto_reload = 1'b0;
        drive(1'b0, 32'd0, 1'b0, 1'b1);

        prescale = 8'd3;
        drive(1'b1, 32'd10, 1'b0, 1'b0);
        drive(1'b0, 32'd0, 1'b1, 1'b0);
        repeat (4) step();
        check("t4_first_dec", count, 32'd9);
        repeat (2) step();
        drive(1'b0, 32'd0, 1'b0, 1'b1);
        check("t4_paused", 32'(running), 32'd0);
        for (int i = 0; i < 10; i++) begin
            step();
            check("t4_hold", count, 32'd9);
        end
        drive(1'b0, 32'd0, 1'b1, 1'b0);
        check("t4_resume_run", 32'(running), 32'd1);
        step();
        check("t4_resume_c1", count, 32'd9);
        step();
        check("t4_resume_c2", count, 32'd8);

        drive(1'b1, 32'd7, 1'b0, 1'b0);
        check("t5_load_ignored", count, 32'd8);
        repeat (3) step();
        check("t5_next_dec", count, 32'd7);

        #3;
        reset = 1'b0;
        #1;
        check("t6_async_count", count, 32'd0);
        check("t6_async_running", 32'(running), 32'd0);
        check("t6_async_done", 32'(done), 32'd0);
        check("t6_async_rc", 32'(reload_count), 32'd0);
        model_reset();
        @(posedge clk);
        #1;
        reset = 1'b1;
        drive(1'b0, 32'd0, 1'b1, 1'b0);
        check("t6_start_ignored", 32'(running), 32'd0);
        drive(1'b1, 32'd7, 1'b1, 1'b0);
        check("t5_ldst_count", count, 32'd7);
        check("t5_ldst_running", 32'(running), 32'd0);
        drive(1'b0, 32'd0, 1'b1, 1'b0);
        check("t5_start_run", 32'(running), 32'd1);

        for (int i = 0; i < 120; i++) begin
            prescale    = 8'($urandom_range(0, 2));
            auto_reload = 1'($urandom_range(0, 1));
            drive($urandom_range(0, 3) == 0, 32'($urandom_range(0, 4)),
                  $urandom_range(0, 2) == 0, $urandom_range(0, 5) == 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
